// File: rtl/button_conditioner.sv
// Front-panel MAGIC/PAUSE conditioner: synchronise, debounce, and stretch each press
// until one frame sample window has seen it; MAGIC also gets a long-press pulse.

module bc_channel #(
  parameter int DEBOUNCE_CYCLES = 280000
) (
  input  logic clk28,
  input  logic rst,
  input  logic n_raw,
  input  logic cond,
  input  logic frame_tick,
  output logic db,
  output logic btn
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SERVED, WAIT_REL} st_t;

  st_t           st;
  logic [1:0]    sync;
  logic          s;
  logic          db_d;
  logic [CW-1:0] cnt;

  assign s = ~sync[1];

  always_ff @(posedge clk28) begin
    if (rst) begin
      sync <= 2'b11;
      db   <= 1'b0;
      db_d <= 1'b0;
      cnt  <= '0;
      st   <= IDLE;
      btn  <= 1'b0;
    end else begin
      sync <= {sync[0], n_raw};
      db_d <= db;

      if (s == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // btn tracks (st == ARMED || st == SERVED), updated alongside st
      case (st)
        IDLE: if (db && !db_d) begin
          st  <= ARMED;
          btn <= 1'b1;
        end
        ARMED: if (frame_tick) st <= SERVED;
        SERVED: if (!cond) begin
          st  <= db ? WAIT_REL : IDLE;
          btn <= 1'b0;
        end
        WAIT_REL: if (!db) st <= IDLE;
        default: begin
          st  <= IDLE;
          btn <= 1'b0;
        end
      endcase
    end
  end
endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 280000,
  parameter int LONG_PRESS_FRAMES = 100
) (
  input  logic clk28,
  input  logic rst,
  input  logic n_magic_raw,
  input  logic n_pause_raw,
  input  logic n_int,
  input  logic n_int_next,
  output logic magic_button,
  output logic pause_button,
  output logic magic_long
);
  localparam int NUM_CH = 2;
  localparam int FW = $clog2(LONG_PRESS_FRAMES + 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(LONG_PRESS_FRAMES - 1);

  logic [NUM_CH-1:0] n_raw;
  logic [NUM_CH-1:0] db;
  logic [NUM_CH-1:0] btn;
  logic              cond;
  logic              cond_d;
  logic              frame_tick;
  logic              fired;
  logic [FW-1:0]     fcnt;

  // channel 0 = MAGIC, channel 1 = PAUSE
  assign n_raw = {n_pause_raw, n_magic_raw};

  assign cond       = n_int & ~n_int_next;
  assign frame_tick = cond & ~cond_d;

  always_ff @(posedge clk28) begin
    if (rst) cond_d <= 1'b0;
    else     cond_d <= cond;
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      bc_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
        .clk28      (clk28),
        .rst        (rst),
        .n_raw      (n_raw[i]),
        .cond       (cond),
        .frame_tick (frame_tick),
        .db         (db[i]),
        .btn        (btn[i])
      );
    end
  endgenerate

  assign magic_button = btn[0];
  assign pause_button = btn[1];

  // Pulse fires on the tick that brings fcnt to LONG_PRESS_FRAMES; fired blocks repeats.
  always_ff @(posedge clk28) begin
    if (rst) begin
      fcnt       <= '0;
      fired      <= 1'b0;
      magic_long <= 1'b0;
    end else begin
      magic_long <= 1'b0;
      if (!db[0]) begin
        fcnt  <= '0;
        fired <= 1'b0;
      end else if (frame_tick && !fired) begin
        fcnt <= fcnt + 1'b1;
        if (fcnt == FCNT_LAST) begin
          magic_long <= 1'b1;
          fired      <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-panel input stage that sits directly upstream of the magic/NMI controller and drives its magic_button and pause_button inputs.
- Synchronises and debounces the raw active-low MAGIC and PAUSE buttons.
- Holds each debounced press until the controller's once-per-frame sample point (n_int falling edge) has seen it, so short taps are never lost.
- Also produces a one-cycle long-press request from the MAGIC button.

Parameters:
DEBOUNCE_CYCLES, 280000, clk28 cycles an input must be stable to change debounced state (10 ms at 28 MHz)
LONG_PRESS_FRAMES, 100, frame ticks MAGIC must stay held to fire magic_long (2 s at 50 Hz)

Ports:
clk28  in  1  system clock, 28 MHz; single clock domain
rst  in  1  synchronous, active-high reset
n_magic_raw  in  1  raw MAGIC button, active-low, asynchronous, bouncy
n_pause_raw  in  1  raw PAUSE button, active-low, asynchronous, bouncy
n_int  in  1  current ULA interrupt line, active-low
n_int_next  in  1  registered next value of n_int
magic_button  out  1  stretched MAGIC press, active-high, registered
pause_button  out  1  stretched PAUSE press, active-high, registered
magic_long  out  1  one-cycle pulse on MAGIC long press

Behaviour:
- Reset (rst=1 at a clk28 edge): magic_button=0, pause_button=0, magic_long=0. All sync FFs load "released" (1), debounced states=0, all counters=0, both channel FSMs=IDLE. Reset may land mid-press or mid-debounce; nothing survives it.
- Synchroniser: 2-FF per raw input. s = ~second FF, giving active-high pressed.
- Debouncer, per channel:
  - db holds the debounced level; cnt is sized to hold DEBOUNCE_CYCLES-1.
  - If s==db, cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: db<=s, cnt<=0.
  - Else cnt<=cnt+1.
  - Latency from a clean raw edge to a db change: 2 + DEBOUNCE_CYCLES cycles.
  - Any glitch shorter than DEBOUNCE_CYCLES never changes db.
- Frame sampling:
  - cond = n_int & ~n_int_next.
  - frame_tick = cond & ~cond_d, where cond_d is cond registered. It is a single-cycle pulse even if cond lasts several cycles.
- Channel FSM, per channel; output = 1 in ARMED and SERVED, 0 otherwise:
  - IDLE: db rising (db=1, db_d=0) -> ARMED.
  - ARMED: frame_tick -> SERVED. A press that releases before the tick stays ARMED, so short taps are latched.
  - SERVED: stays while cond=1, which keeps the output high through the whole window the controller samples. When cond=0: -> WAIT_REL if db=1, -> IDLE if db=0.
  - WAIT_REL: db=0 -> IDLE.
  - Result: exactly one frame window is served per press; holding the button does not repeat.
- Simultaneous events:
  - db rising in the same cycle as frame_tick while IDLE goes to ARMED only; the press is served at the next frame_tick.
  - In ARMED, frame_tick takes priority over db changes.
- Long press, MAGIC channel only:
  - fcnt is sized to LONG_PRESS_FRAMES.
  - While db_magic=0: fcnt<=0 and the fired flag is cleared.
  - While db_magic=1 and a frame_tick occurs and not fired: fcnt<=fcnt+1.
  - When fcnt reaches LONG_PRESS_FRAMES: magic_long=1 for exactly one cycle and fired<=1. No repeat until db_magic returns to 0.
  - magic_button behaviour is unaffected by a long press.
- Channels are fully independent; both may be ARMED or SERVED at once.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
(DEBOUNCE_CYCLES=8, LONG_PRESS_FRAMES=3, frame = cond high for 4 cycles every 200 cycles)
- Reset check: assert rst for 3 cycles with n_magic_raw=0 held -> all outputs 0 during reset. magic_button rises 2+8 cycles after rst deasserts and falls only after the next cond window ends.
- Bounce rejection: toggle n_pause_raw every 3 cycles for 40 cycles, then hold 1 -> pause_button stays 0 throughout.
- Short tap: n_magic_raw=0 for 12 cycles at cycle 20, released well before the next frame -> magic_button=1 from about cycle 31 through the end of the next 4-cycle cond window, then 0. It is not reasserted in the following frame.
- Held press: n_pause_raw=0 for 5 frames -> pause_button is high for exactly one frame window. After release plus a new press, it is served again at the next frame.
- Edge coincidence: arrange db_magic rising on the exact frame_tick cycle -> the press is not served that frame and magic_button stays high until the end of the following cond window.
- Long press: hold MAGIC for 5 frames -> exactly one magic_long pulse of one cycle, on the cycle after the third frame_tick. Release for under 3 frames and press again -> no pulse until 3 more ticks.
